// File: rtl/is_uart_rx_ctrl.sv
// UART receive controller: oversampled start/data/parity/stop sampling with a
// valid/ready byte output, frame/parity error status and overrun pulse.
module is_uart_rx_ctrl #(
    parameter int RATIO      = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_ce_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(RATIO);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(RATIO / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
    localparam logic          PEN_BIT  = (PARITY_EN != 0);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [BW-1:0]          bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_err_r;
    logic                   frame_done_s;

    // Result is 1 when data plus received parity bit disagree with the selected parity sense.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] data,
                                      input logic par_bit,
                                      input logic odd);
        return (^data) ^ par_bit ^ odd;
    endfunction

    // Stop-bit sample tick: the frame is complete on this cycle.
    always_comb begin
        frame_done_s = 1'b0;
        if (uart_ce_i && (state_r == ST_STOP) && (cnt_r == CNT_LAST)) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Receive sequencer: every state change and counter update is gated by the oversample tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= {BW{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            par_err_r <= 1'b0;
            busy_o    <= 1'b0;
        end else if (uart_ce_i) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_i) begin
                        state_r <= ST_START;
                        cnt_r   <= {CW{1'b0}};
                        busy_o  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_HALF) begin
                        if (!rx_i) begin
                            state_r   <= ST_DATA;
                            cnt_r     <= {CW{1'b0}};
                            bit_idx_r <= {BW{1'b0}};
                        end else begin
                            // Line went back high before mid-start: a glitch, not a frame.
                            state_r <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {rx_i, shift_r[DATA_BITS-1:1]};
                        if (bit_idx_r == IDX_LAST) begin
                            state_r <= PEN_BIT ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + BW'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        par_err_r <= parity_f(shift_r, rx_i, ODD_BIT);
                        state_r   <= ST_STOP;
                        cnt_r     <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= {CW{1'b0}};
                        if (rx_i) begin
                            state_r <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            state_r <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before another start can be seen.
                    if (rx_i) begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: load on completion if free or being drained, else flag overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_o    <= {DATA_BITS{1'b0}};
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (frame_done_s) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o    <= shift_r;
                    frame_err_o  <= ~rx_i;
                    parity_err_o <= PEN_BIT & par_err_r;
                    rx_valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/is_uart_rx_ctrl.md
# is_uart_rx_ctrl

UART receive controller: sequences the oversampling counter, validates the start bit, samples data, parity and stop bits at bit centre, and presents each received frame on a valid/ready byte interface with error status. It sits between the baud-rate tick generator (`uart_ce_i`) and the receive FIFO / register file of the UART controller. It is self-contained: the oversample counter and its restart logic are internal.

## Interface
- `RATIO`, 16: oversample ticks per bit; power of two, ≥4; from `is_pkg_uart_controller`.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY_EN`, 0: 1 = one parity bit follows the data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN`=0.

- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `uart_ce_i`  in  1  oversample tick, one `clk_i` cycle wide, RATIO per bit period.
- `rx_i`  in  1  serial line, already synchronised to `clk_i`; idle high.
- `rx_data_o`  out  DATA_BITS  received data, LSB = first bit on the line.
- `rx_valid_o`  out  1  frame available; held until accepted.
- `rx_ready_i`  in  1  consumer accepts when `rx_valid_o`&`rx_ready_i`.
- `frame_err_o`  out  1  stop bit sampled 0; qualified by `rx_valid_o`.
- `parity_err_o`  out  1  parity mismatch; qualified by `rx_valid_o`; 0 when `PARITY_EN`=0.
- `overrun_o`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy_o`  out  1  1 in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK. All transitions and counter updates occur only on cycles with `uart_ce_i`=1; with `uart_ce_i`=0 the state and counters hold.
- Internal `cnt` is $clog2(RATIO) bits wide and wraps naturally. Internal `bit_idx` counts 0..DATA_BITS-1.
- IDLE: on a tick with `rx_i`=0, go to START and set `cnt`<=0.
- START: increment `cnt` on each tick. On the tick where `cnt`==RATIO/2-1:
  - `rx_i`=0: go to DATA, `cnt`<=0, `bit_idx`<=0.
  - `rx_i`=1: treat as a glitch and return to IDLE; no output activity.
- DATA: increment `cnt` on each tick. On the tick where `cnt`==RATIO-1:
  - shift `rx_i` into the shift register, LSB-first; `cnt`<=0.
  - after bit DATA_BITS-1, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: on the tick where `cnt`==RATIO-1, compute the error bit as XOR(data, parity bit, `PARITY_ODD`); go to STOP with `cnt`<=0.
- STOP: on the tick where `cnt`==RATIO-1, complete the frame:
  - `rx_i`=1: go to IDLE.
  - `rx_i`=0: set the frame error and go to BREAK.
- BREAK: wait for a tick with `rx_i`=1, then go to IDLE. Line low in this state never starts a frame.
- Frame completion with `rx_valid_o`=0, or with `rx_valid_o`&`rx_ready_i` in the same cycle:
  - load `rx_data_o`, `frame_err_o` and `parity_err_o`;
  - `rx_valid_o`<=1.
- Frame completion with `rx_valid_o`=1 and `rx_ready_i`=0:
  - the new frame is discarded and the held outputs are unchanged;
  - `overrun_o`=1 for one cycle.
- Acceptance without a completion in that cycle: `rx_valid_o`<=0; data and error outputs hold their last value.
- `rst_i` asserted mid-frame aborts the frame immediately. No partial data is ever presented.

## Timing
- Reset values:
  - `rx_data_o`=0, `rx_valid_o`=0, `frame_err_o`=0, `parity_err_o`=0, `overrun_o`=0, `busy_o`=0;
  - state=IDLE, `cnt`=0, `bit_idx`=0.
- All outputs are registered; none has a combinational path from inputs.
- Sample points, with T0 = the start-detect tick and tick offsets counted in `uart_ce_i` pulses:
  - start verify at T0+RATIO/2;
  - data bit k at T0+RATIO/2+(k+1)·RATIO;
  - parity at T0+RATIO/2+(DATA_BITS+1)·RATIO;
  - stop one RATIO after the last data or parity bit.
- `rx_valid_o` rises on the `clk_i` edge of the stop-sample tick (visible the next cycle).
- After a good stop bit the block is in IDLE and can detect the next start bit on the very next tick. Back-to-back frames with a single stop bit are received without loss.
- `busy_o` rises the cycle after T0 and falls the cycle after the stop sample, or after leaving BREAK.

## Test plan
- RATIO=16, 8N1, send 0xA5 with ideal timing, `rx_ready_i`=1 -> `rx_data_o`=0xA5, `rx_valid_o` high exactly 1 cycle, both error outputs 0, `rx_valid_o` rising at tick T0+152.
- Low pulse of 4 ticks on an idle line -> returns to IDLE at T0+8, `rx_valid_o` never asserts, `busy_o` pulses high.
- Send 0x3C with stop bit 0, line held low for 30 further ticks -> `rx_valid_o`=1, `frame_err_o`=1, `rx_data_o`=0x3C; no new frame starts until the line returns high.
- `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 with parity bit 0 -> `parity_err_o`=1; resend with parity bit 1 -> `parity_err_o`=0.
- `rx_ready_i`=0, send 0x11 then 0x22 back-to-back -> `rx_data_o` stays 0x11 and `overrun_o` pulses once. Then raise `rx_ready_i` in the same cycle a third frame 0x33 completes -> 0x11 is accepted, `rx_data_o`=0x33, `rx_valid_o` stays 1.
- Assert `rst_i` during data bit 4 of a frame -> all outputs return to reset values immediately; the next full frame 0x5A is received correctly.
